// File: rtl/issue_queue.sv
// In-order instruction queue feeding the adder and multiplier reservation stations.
// The FIFO head is decoded each cycle and issued only when its target station has room.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Flush,
  input  logic [15:0]   InstIn,
  input  logic          InstValid,
  output logic          InstReady,
  input  logic [7:0]    AdderBusy,
  input  logic [7:0]    MulBusy,
  output logic [15:0]   instruction,
  output logic          Adderin,
  output logic          Mulin,
  output logic          Illegal,
  output logic [AW:0]   Count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   instr_q, instr_d;
  logic          add_q, add_d, mul_q, mul_d, ill_q, ill_d;

  logic [15:0]   head;
  logic [3:0]    add_free, mul_free, add_need, mul_need;
  logic          empty, full, issue_add, issue_mul, drop_ill, pop, push;

  assign head     = mem_q[rd_ptr_q];
  assign empty    = (count_q == {(AW+1){1'b0}});
  assign full     = (count_q == FULL_CNT);
  assign add_free = popcount8(~AdderBusy);
  assign mul_free = popcount8(~MulBusy);
  // A strobe issued last edge is not yet visible in Busy, so one more line must be free.
  assign add_need = add_q ? 4'd2 : 4'd1;
  assign mul_need = mul_q ? 4'd2 : 4'd1;

  assign issue_add = !empty && (head[3:2] == 2'b00) && (add_free >= add_need);
  assign issue_mul = !empty && (head[3:2] == 2'b01) && (mul_free >= mul_need);
  assign drop_ill  = !empty && head[3];
  assign pop       = issue_add || issue_mul || drop_ill;
  assign InstReady = !full || pop;
  assign push      = InstValid && InstReady;

  always_comb begin
    count_d = count_q;
    instr_d = instr_q;
    add_d   = 1'b0;
    mul_d   = 1'b0;
    ill_d   = 1'b0;
    if (Flush) begin
      count_d = {(AW+1){1'b0}};
    end else begin
      if (push && !pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (!push && pop) begin
        count_d = count_q - (AW+1)'(1);
      end else begin
        count_d = count_q;
      end
      if (issue_add || issue_mul) begin
        instr_d = head;
      end else begin
        instr_d = instr_q;
      end
      add_d = issue_add;
      mul_d = issue_mul;
      ill_d = drop_ill;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      instr_q  <= 16'h0000;
      add_q    <= 1'b0;
      mul_q    <= 1'b0;
      ill_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else begin
      count_q <= count_d;
      instr_q <= instr_d;
      add_q   <= add_d;
      mul_q   <= mul_d;
      ill_q   <= ill_d;
      if (Flush) begin
        wr_ptr_q <= {AW{1'b0}};
        rd_ptr_q <= {AW{1'b0}};
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= InstIn;
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
    end
  end

  assign instruction = instr_q;
  assign Adderin     = add_q;
  assign Mulin       = mul_q;
  assign Illegal     = ill_q;
  assign Count       = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: hand table, corner sequences, and random traffic
// compared against a queue-based reference model.
module tb_issue_queue;

  logic        Clock, Reset, Flush, InstValid, InstReady;
  logic [15:0] InstIn, instruction;
  logic [7:0]  AdderBusy, MulBusy;
  logic        Adderin, Mulin, Illegal;
  logic [3:0]  Count;

  issue_queue #(.DEPTH(8), .AW(3)) dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .InstIn(InstIn), .InstValid(InstValid),
    .InstReady(InstReady), .AdderBusy(AdderBusy), .MulBusy(MulBusy),
    .instruction(instruction), .Adderin(Adderin), .Mulin(Mulin), .Illegal(Illegal),
    .Count(Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [15:0] mq[$];
  logic [15:0] m_instr;
  logic        m_add, m_mul, m_ill;

  typedef struct {
    logic        v;
    logic [15:0] inst;
    logic [7:0]  ab, mb;
    logic        e_add, e_mul, e_ill;
    int          e_cnt;
    logic [15:0] e_instr;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_instr = 16'h0000;
    m_add = 1'b0; m_mul = 1'b0; m_ill = 1'b0;
  endtask

  // One clock: drive inputs, check InstReady, advance model and compare after the edge.
  task automatic step(input logic v, input logic [15:0] inst, input logic [7:0] ab,
                      input logic [7:0] mb, input logic fl);
    logic ia, im, il, rdy;
    logic [3:0] op;
    ia = 1'b0; im = 1'b0; il = 1'b0;
    InstValid = v; InstIn = inst; AdderBusy = ab; MulBusy = mb; Flush = fl;
    if (mq.size() != 0) begin
      op = mq[0][3:0];
      if (op >= 4'd8)      il = 1'b1;
      else if (op < 4'd4)  ia = ($countones(~ab) >= (m_add ? 2 : 1));
      else                 im = ($countones(~mb) >= (m_mul ? 2 : 1));
    end
    rdy = (mq.size() < 8) || ia || im || il;
    #1;
    chk("InstReady", {31'd0, InstReady}, {31'd0, rdy});
    @(posedge Clock);
    #1;
    n_vec++;
    if (fl) begin
      mq.delete();
      m_add = 1'b0; m_mul = 1'b0; m_ill = 1'b0;
    end else begin
      if (ia || im) m_instr = mq[0];
      if (ia || im || il) void'(mq.pop_front());
      if (v && rdy) mq.push_back(inst);
      m_add = ia; m_mul = im; m_ill = il;
    end
    chk("Count", {28'd0, Count}, mq.size());
    chk("instruction", {16'd0, instruction}, {16'd0, m_instr});
    chk("Adderin", {31'd0, Adderin}, {31'd0, m_add});
    chk("Mulin", {31'd0, Mulin}, {31'd0, m_mul});
    chk("Illegal", {31'd0, Illegal}, {31'd0, m_ill});
  endtask

  function automatic vec_t mk(input logic v, input logic [15:0] inst, input logic [7:0] ab,
                              input logic [7:0] mb, input logic ea, input logic em,
                              input logic ei, input int ec, input logic [15:0] eins);
    vec_t r;
    r.v = v; r.inst = inst; r.ab = ab; r.mb = mb;
    r.e_add = ea; r.e_mul = em; r.e_ill = ei; r.e_cnt = ec; r.e_instr = eins;
    return r;
  endfunction

  initial begin
    logic [3:0]  op;
    logic [15:0] ins;
    logic [7:0]  ab, mb;
    int          sel;

    // single ADD, latency 2 edges
    tbl[0]  = mk(1'b1, 16'h0381, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1, 16'h0000);
    tbl[1]  = mk(1'b0, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 16'h0381);
    tbl[2]  = mk(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0, 16'h0381);
    // head ADD blocked holds the younger MUL
    tbl[3]  = mk(1'b1, 16'h0012, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1, 16'h0381);
    tbl[4]  = mk(1'b1, 16'h0025, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 2, 16'h0381);
    tbl[5]  = mk(1'b0, 16'h0000, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 1, 16'h0012);
    tbl[6]  = mk(1'b0, 16'h0000, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 0, 16'h0025);
    tbl[7]  = mk(1'b0, 16'h0000, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 0, 16'h0025);
    // one free adder line: second ADD must wait for the in-flight strobe
    tbl[8]  = mk(1'b1, 16'h0101, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1, 16'h0025);
    tbl[9]  = mk(1'b1, 16'h0102, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 1, 16'h0101);
    tbl[10] = mk(1'b0, 16'h0000, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1, 16'h0101);
    tbl[11] = mk(1'b0, 16'h0000, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1, 16'h0101);
    tbl[12] = mk(1'b0, 16'h0000, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 0, 16'h0102);
    tbl[13] = mk(1'b0, 16'h0000, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 0, 16'h0102);
    // illegal opcode dropped
    tbl[14] = mk(1'b1, 16'h000A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1, 16'h0102);
    tbl[15] = mk(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 0, 16'h0102);
    tbl[16] = mk(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0, 16'h0102);
    // two free mul lines allow back-to-back MUL issue
    tbl[17] = mk(1'b1, 16'h0004, 8'h00, 8'hFC, 1'b0, 1'b0, 1'b0, 1, 16'h0102);
    tbl[18] = mk(1'b1, 16'h0007, 8'h00, 8'hFC, 1'b0, 1'b1, 1'b0, 1, 16'h0004);
    tbl[19] = mk(1'b0, 16'h0000, 8'h00, 8'hFC, 1'b0, 1'b1, 1'b0, 0, 16'h0007);
    tbl[20] = mk(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0, 16'h0007);

    Reset = 1'b1; Flush = 1'b0; InstValid = 1'b0; InstIn = 16'h0000;
    AdderBusy = 8'h00; MulBusy = 8'h00;
    model_reset();
    @(posedge Clock); @(posedge Clock); #1;
    chk("rst_count", {28'd0, Count}, 32'd0);
    chk("rst_ready", {31'd0, InstReady}, 32'd1);
    chk("rst_instr", {16'd0, instruction}, 32'h0);
    chk("rst_strobes", {29'd0, Adderin, Mulin, Illegal}, 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].v, tbl[i].inst, tbl[i].ab, tbl[i].mb, 1'b0);
      chk($sformatf("tbl%0d_add", i), {31'd0, Adderin}, {31'd0, tbl[i].e_add});
      chk($sformatf("tbl%0d_mul", i), {31'd0, Mulin}, {31'd0, tbl[i].e_mul});
      chk($sformatf("tbl%0d_ill", i), {31'd0, Illegal}, {31'd0, tbl[i].e_ill});
      chk($sformatf("tbl%0d_cnt", i), {28'd0, Count}, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_ins", i), {16'd0, instruction}, {16'd0, tbl[i].e_instr});
    end

    // fill to full with both stations busy
    for (int i = 0; i < 8; i++) step(1'b1, 16'h1000 + 16'(i), 8'hFF, 8'hFF, 1'b0);
    chk("full_count", {28'd0, Count}, 32'd8);
    InstValid = 1'b1; #1;
    chk("full_ready", {31'd0, InstReady}, 32'd0);
    step(1'b1, 16'h1008, 8'hFF, 8'hFF, 1'b0);
    chk("full_nopush", {28'd0, Count}, 32'd8);
    step(1'b1, 16'h1009, 8'h7F, 8'hFF, 1'b0);
    chk("full_pushpop_cnt", {28'd0, Count}, 32'd8);
    chk("full_pushpop_add", {31'd0, Adderin}, 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0);
    chk("drain_count", {28'd0, Count}, 32'd0);

    // flush with a concurrent push
    for (int i = 0; i < 5; i++) step(1'b1, 16'h2004 + 16'(i), 8'hFF, 8'hFF, 1'b0);
    chk("preflush_count", {28'd0, Count}, 32'd5);
    step(1'b1, 16'h2010, 8'h00, 8'h00, 1'b1);
    chk("flush_count", {28'd0, Count}, 32'd0);
    chk("flush_strobe", {30'd0, Adderin, Mulin}, 32'd0);

    // asynchronous reset while a strobe is high
    step(1'b1, 16'h0383, 8'h00, 8'h00, 1'b0);
    step(1'b0, 16'h0000, 8'h00, 8'h00, 1'b0);
    chk("pre_rst_add", {31'd0, Adderin}, 32'd1);
    Reset = 1'b1; #1;
    chk("async_rst_add", {31'd0, Adderin}, 32'd0);
    chk("async_rst_count", {28'd0, Count}, 32'd0);
    model_reset();
    #2 Reset = 1'b0;

    // random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      op = 4'($urandom_range(0, 3));
      else if (sel < 8) op = 4'($urandom_range(4, 7));
      else              op = 4'($urandom_range(8, 15));
      ins = 16'($urandom);
      ins[3:0] = op;
      sel = int'($urandom_range(0, 3));
      ab = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? ~(8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      sel = int'($urandom_range(0, 3));
      mb = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? ~(8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      step($urandom_range(0, 3) != 0, ins, ab, mb, $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
